instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the pipeline instruction decoder: accepts field-level instruction requests and emits encoded 32-bit MIPS words with sequential word addresses for instruction-memory preload.
- Sits between the test/boot loader and the IM write port.
- Covers the supported subset: nop, add, sub, jr, ori, lw, sw, beq, lui, jal, lb, sb, bltzal.
- Has a one-deep registered output stage with valid/ready on both sides.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first emitted word.
- DEPTH, 1024, maximum number of words emitted before the block saturates.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the cycle req_valid&&req_ready
- req_op  in  4  0 nop, 1 add, 2 sub, 3 jr, 4 ori, 5 lw, 6 sw, 7 beq, 8 lui, 9 jal, 10 lb, 11 sb, 12 bltzal, 13-15 illegal
- req_rs  in  5  rs field
- req_rt  in  5  rt field
- req_rd  in  5  rd field
- req_imm  in  16  immediate/offset
- req_target  in  26  jal target index
- restart  in  1  synchronous: clear word count and error, drop pending output
- im_valid  out  1  encoded word valid
- im_ready  in  1  IM write accepted
- im_addr  out  32  byte address of word
- im_data  out  32  encoded instruction
- word_count  out  11  words accepted so far, 0..DEPTH
- done  out  1  word_count==DEPTH
- err_illegal  out  1  sticky, set by an illegal op request

Behaviour:
- Reset is asynchronous on rst_n low. All outputs reset to 0: im_valid, im_addr, im_data, word_count, done and err_illegal. req_ready follows its equation.
- req_ready = !done && (!im_valid || im_ready). Transfer-while-draining is allowed, so the block sustains 1 word/cycle.
- Accepting a legal op loads the output register the next edge:
  - im_valid=1
  - im_addr=BASE_ADDR+4*word_count (pre-increment value)
  - word_count+1
  - im_data is fixed per op.
- Encodings of im_data:
  - nop: 32'h0
  - add: {000000,rs,rt,rd,00000,100000}
  - sub: as add with funct 100010
  - jr: {000000,rs,15'b0,001000}
  - ori/lw/sw/beq/lb/sb: {op,rs,rt,imm}, with opcodes 001101/100011/101011/000100/100000/101000
  - lui: {001111,00000,rt,imm}
  - jal: {000011,target}
  - bltzal: {111110,rs,00000,imm}
- Unused request fields are ignored: rt/rd/imm of jr, and rd of I-types.
- Accepting an illegal op (13-15):
  - request is consumed
  - err_illegal<=1 (sticky)
  - no word emitted, word_count unchanged
  - output register: holds a pending word until im_ready; clears im_valid if it was draining this cycle.
- Output stage: im_valid stays high, and im_addr/im_data stay stable, until im_ready. Fall to 0 when drained with no new accept.
- Saturation: once word_count==DEPTH, done=1 and req_ready=0. The final pending word still drains normally.
- restart has priority over an accept in the same cycle:
  - word_count<=0, err_illegal<=0, im_valid<=0, done<=0
  - the request on that cycle is not accepted; req_ready is forced 0 while restart=1.
- rst_n low mid-transfer aborts immediately and the pending word is lost. The first accept after release uses BASE_ADDR.
- word_count width covers DEPTH inclusive; addresses wrap modulo 2^32 only if BASE_ADDR is near top (not guarded).

Test Plan:
- Reset, then a single add with rs=1 rt=2 rd=3, im_ready=1 -> next cycle im_valid=1, im_addr=0x3000, im_data=0x00221820, word_count=1.
- Back-to-back ori rs=0 rt=8 imm=0x1234, then lw rs=8 rt=9 imm=4, then jal target=0x0C00 -> data 0x34081234 @0x3000, 0x8D090004 @0x3004, 0x0C000C00 @0x3008, one per cycle.
- im_ready held 0 for 3 cycles with the request stream on -> req_ready=0 and im_addr/im_data stable. Release -> stream resumes, no word lost or duplicated.
- Illegal op 14 between two sw words -> err_illegal=1, addresses stay consecutive (0x3000, 0x3004), no gap.
- DEPTH=4 override: 5 requests -> 4 words emitted, done=1, 5th req_ready=0. restart -> word_count=0, done=0, next word @0x3000.
- bltzal rs=5 imm=0xFFFE, then rst_n pulsed low while im_valid=1 -> first shows data 0xF8A0FFFE; after reset im_valid=0 asynchronously and word_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Field-level MIPS instruction encoder feeding the instruction-memory preload port.
// Converts one request per cycle into a 32-bit word at the next sequential address.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [15:0] req_imm,
  input  logic [25:0] req_target,
  input  logic        restart,
  output logic        im_valid,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_data,
  output logic [10:0] word_count,
  output logic        done,
  output logic        err_illegal
);

  localparam logic [10:0] DEPTH_W = 11'(DEPTH);

  logic        accept;
  logic        op_legal;
  logic [31:0] enc_data;
  logic [31:0] addr_next;

  assign done      = (word_count == DEPTH_W);
  assign req_ready = !restart && !done && (!im_valid || im_ready);
  assign accept    = req_valid && req_ready;
  assign addr_next = BASE_ADDR + {19'b0, word_count, 2'b00};

  // Fields a given format does not use are simply not routed into the word.
  always_comb begin
    op_legal = 1'b1;
    enc_data = 32'h0;
    case (req_op)
      4'd0:  enc_data = 32'h0;
      4'd1:  enc_data = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100000};
      4'd2:  enc_data = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, 6'b100010};
      4'd3:  enc_data = {6'b000000, req_rs, 15'b0, 6'b001000};
      4'd4:  enc_data = {6'b001101, req_rs, req_rt, req_imm};
      4'd5:  enc_data = {6'b100011, req_rs, req_rt, req_imm};
      4'd6:  enc_data = {6'b101011, req_rs, req_rt, req_imm};
      4'd7:  enc_data = {6'b000100, req_rs, req_rt, req_imm};
      4'd8:  enc_data = {6'b001111, 5'b00000, req_rt, req_imm};
      4'd9:  enc_data = {6'b000011, req_target};
      4'd10: enc_data = {6'b100000, req_rs, req_rt, req_imm};
      4'd11: enc_data = {6'b101000, req_rs, req_rt, req_imm};
      4'd12: enc_data = {6'b111110, req_rs, 5'b00000, req_imm};
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_valid    <= 1'b0;
      im_addr     <= 32'h0;
      im_data     <= 32'h0;
      word_count  <= 11'd0;
      err_illegal <= 1'b0;
    end else if (restart) begin
      im_valid    <= 1'b0;
      word_count  <= 11'd0;
      err_illegal <= 1'b0;
    end else begin
      if (accept && op_legal) begin
        im_valid   <= 1'b1;
        im_addr    <= addr_next;
        im_data    <= enc_data;
        word_count <= word_count + 11'd1;
      end else if (im_ready) begin
        im_valid <= 1'b0;
      end
      // An illegal request is consumed without producing a word.
      if (accept && !op_legal)
        err_illegal <= 1'b1;
    end
  end

endmodule
